msk_seq_demux: RTL and testbench
================================

// Module: msk_seq_demux
// PURPOSE
//  Masked serial-to-parallel demultiplexer: inverse of the masked share mux.
//  - Accepts one masked bundle per cycle (count sharings of d shares) on a valid/ready input.
//  - Writes consecutive bundles to NLANES lane registers in order; presents all lanes together.
//  - Sits between serial share sources (PRNG-fed loaders, bus adapters) and parallel gadget inputs.
//  - Share-domain safe: routing and register only; no logic ever combines two shares.
// PARAMETERS
//  d       1  number of shares per sharing (masking order + 1)
//  count   1  sharings per input bundle
//  NLANES  4  lanes per output frame; >= 2
// PORTS
//  clk        in   1                 clock, rising edge
//  rst        in   1                 synchronous reset, active-high
//  in_valid   in   1                 input bundle valid
//  in_ready   out  1                 block accepts a bundle this cycle
//  in_last    in   1                 accepted bundle closes frame early (short frame)
//  in_data    in   count*d           masked bundle (sharing, latency 0 to the lane register)
//  out_valid  out  1                 frame complete, out_data stable
//  out_ready  in   1                 consumer takes the frame
//  out_nlanes out  clog2(NLANES+1)   number of lanes written in the presented frame
//  out_data   out  NLANES*count*d    lane k at [k*count*d +: count*d]; lane 0 = first bundle
// BEHAVIOUR
//  - States: FILL, FULL. Lane index idx, 0..NLANES-1.
//  - Reset (rst=1 at posedge): state<=FILL, idx<=0, all lanes<=0, out_nlanes<=0.
//    After reset, out_valid=0 and in_ready=1.
//    Inputs are ignored during any cycle with rst=1, including reset mid-frame; partial data is discarded.
//  - Output decode: in_ready = (state==FILL); out_valid = (state==FULL). Both are decoded from state only.
//  - Accept in FILL when in_valid&in_ready:
//    - lane[idx] <= in_data.
//    - If idx==NLANES-1 or in_last: lanes idx+1..NLANES-1 <= 0 (the zero sharing),
//      out_nlanes <= idx+1, idx <= 0, state <= FULL.
//    - Otherwise idx <= idx+1.
//  - in_last on the lane NLANES-1 bundle behaves the same as a full frame.
//  - FILL with in_valid=0: no change; the partial frame is held indefinitely.
//  - FULL: out_data and out_nlanes are held stable.
//    - On out_ready=1: state <= FILL.
//    - in_ready is 0 during the handoff cycle; there is no bypass. Minimum frame period = lanes + 1 cycles.
//  - Latency: the last accepted bundle appears on out_data with out_valid=1 one cycle after acceptance.
//  - out_data is driven only from lane flops; no combinational path from in_* to out_*.
//  - Lanes update only when written (FILL accept) or zeroed (frame close).
//    Lanes from the previous frame below the new idx remain until overwritten.
//  - Shares are never XORed, ANDed or reordered. Share i of an input sharing lands in share i of its lane.
// TESTING
//  1. Reset, NLANES=4, d=2, count=1; feed 2'b01,2'b10,2'b11,2'b00 back-to-back
//     -> out_valid=1 the cycle after the 4th accept, out_data=8'b00_11_10_01, out_nlanes=4, in_ready=0.
//  2. Frame held with out_ready=0 for 5 cycles while in_valid=1
//     -> out_data stable and no input accepted; out_ready=1 -> next cycle in_ready=1, out_valid=0.
//  3. Short frame: 2'b11 then 2'b10 with in_last=1
//     -> out_data=8'b00_00_10_11, out_nlanes=2.
//  4. Reset after 3 of 4 accepts
//     -> lanes=0, idx=0; 4 new bundles then form a clean frame with no stale lane data.
//  5. in_valid toggled 1,0,0,1,1,0,1 -> exactly 4 accepts, ordered by acceptance cycle, one frame.
//  6. d=3, count=2, random sharings over 1000 frames
//     -> each lane equals the accepted bundle bit-for-bit, so the per-share unmasked value is preserved.

Source files
------------

// File: rtl/msk_seq_demux.sv
// Masked serial-to-parallel demultiplexer.
// Collects up to NLANES masked bundles, one per accepted cycle, into lane
// registers and presents them together as one frame. A bundle flagged with
// in_last closes the frame early. Unwritten upper lanes are then cleared to
// the zero sharing.
// Data is only routed and registered. Shares are never combined, so share i of
// an input sharing always lands in share i of its lane.
//
// state | meaning
// ------+------------------------------------------------------------------
// FILL  | accepting bundles into lane[idx]; the partial frame is held while idle
// FULL  | frame presented on out_data; waiting for out_ready
module msk_seq_demux #(
   parameter int d      = 1,
   parameter int count  = 1,
   parameter int NLANES = 4
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   input  logic                                 in_last,
   input  logic [count*d-1:0]                   in_data,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic [$clog2(NLANES+1)-1:0]          out_nlanes,
   output logic [NLANES*count*d-1:0]            out_data
);

   localparam int W  = count * d;
   localparam int IW = (NLANES > 1) ? $clog2(NLANES) : 1;
   localparam int NW = $clog2(NLANES + 1);

   typedef enum logic {
      FILL = 1'b0,
      FULL = 1'b1
   } state_t;

   state_t                     state_q, state_d;
   logic [IW-1:0]              idx_q, idx_d;
   logic [NLANES-1:0][W-1:0]   lanes_q, lanes_d;
   logic [NW-1:0]              nlanes_q, nlanes_d;
   logic                       accept;
   logic                       close;

   // Handshake outputs decode from state only, so there is no in_* to out_* path.
   assign in_ready   = (state_q == FILL);
   assign out_valid  = (state_q == FULL);
   assign out_nlanes = nlanes_q;
   assign out_data   = lanes_q;

   assign accept = (state_q == FILL) && in_valid;
   assign close  = accept && ((idx_q == IW'(NLANES - 1)) || in_last);

   // Next state: write the current lane, close the frame on the last lane or on in_last,
   // and release the frame on out_ready.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      lanes_d  = lanes_q;
      nlanes_d = nlanes_q;
      case (state_q)
         FILL: begin
            if (accept) begin
               lanes_d[idx_q] = in_data;
               if (close) begin
                  // Short frames leave the upper lanes as the zero sharing, not stale shares.
                  for (int k = 0; k < NLANES; k++) begin
                     if (k > int'(idx_q)) begin
                        lanes_d[k] = '0;
                     end
                  end
                  nlanes_d = NW'(idx_q) + NW'(1);
                  idx_d    = '0;
                  state_d  = FULL;
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end
         end
         FULL: begin
            if (out_ready) begin
               state_d = FILL;
            end
         end
         default: begin
            state_d = FILL;
         end
      endcase
   end

   // State and lane registers. Reset discards any partial frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= FILL;
         idx_q    <= '0;
         lanes_q  <= '0;
         nlanes_q <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         lanes_q  <= lanes_d;
         nlanes_q <= nlanes_d;
      end
   end

endmodule

// File: tb/tb_msk_seq_demux.sv
// Bench for msk_seq_demux.
// Instance A uses d=2, count=1, NLANES=4 and runs the directed scenarios.
// Instance B uses d=3, count=2, NLANES=4 and runs randomized frames.
// Expected frames are pushed to a queue when a frame closes. They are compared
// while the DUT presents them and popped when the consumer takes them.
module tb_msk_seq_demux;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // instance A: d=2, count=1
   logic        in_valid_a, in_ready_a, in_last_a, out_valid_a, out_ready_a;
   logic [1:0]  in_data_a;
   logic [2:0]  out_nlanes_a;
   logic [7:0]  out_data_a;

   // instance B: d=3, count=2
   logic        in_valid_b, in_ready_b, in_last_b, out_valid_b, out_ready_b;
   logic [5:0]  in_data_b;
   logic [2:0]  out_nlanes_b;
   logic [23:0] out_data_b;

   msk_seq_demux #(.d(2), .count(1), .NLANES(4)) dut_a (
      .clk(clk), .rst(rst),
      .in_valid(in_valid_a), .in_ready(in_ready_a), .in_last(in_last_a), .in_data(in_data_a),
      .out_valid(out_valid_a), .out_ready(out_ready_a),
      .out_nlanes(out_nlanes_a), .out_data(out_data_a)
   );

   msk_seq_demux #(.d(3), .count(2), .NLANES(4)) dut_b (
      .clk(clk), .rst(rst),
      .in_valid(in_valid_b), .in_ready(in_ready_b), .in_last(in_last_b), .in_data(in_data_b),
      .out_valid(out_valid_b), .out_ready(out_ready_b),
      .out_nlanes(out_nlanes_b), .out_data(out_data_b)
   );

   // bench-side expectation state
   logic        ea_fill;
   int          ea_idx;
   logic [7:0]  ea_frame;
   logic [10:0] qa[$];
   int          accepts_a;

   logic        eb_fill;
   int          eb_idx;
   logic [23:0] eb_frame;
   logic [26:0] qb[$];
   int          frames_b;

   // One cycle on instance A: drive inputs at negedge, check outputs, advance the expectation.
   task automatic tick_a(input logic v, input logic [1:0] data, input logic last, input logic ordy);
      @(negedge clk);
      in_valid_a = v; in_data_a = data; in_last_a = last; out_ready_a = ordy;
      #1;
      checks++;
      if (in_ready_a !== ea_fill) begin
         failures++;
         $display("FAIL a_in_ready got=%b exp=%b t=%0t", in_ready_a, ea_fill, $time);
      end
      checks++;
      if (out_valid_a !== ~ea_fill) begin
         failures++;
         $display("FAIL a_out_valid got=%b exp=%b t=%0t", out_valid_a, ~ea_fill, $time);
      end
      if (!ea_fill) begin
         checks++;
         if (qa.size() == 0) begin
            failures++;
            $display("FAIL a_frame no expected frame queued t=%0t", $time);
         end else begin
            if ({out_nlanes_a, out_data_a} !== qa[0]) begin
               failures++;
               $display("FAIL a_frame got n=%0d data=%h exp n=%0d data=%h t=%0t",
                        out_nlanes_a, out_data_a, qa[0][10:8], qa[0][7:0], $time);
            end
            if (ordy) begin
               void'(qa.pop_front());
               ea_fill = 1'b1;
            end
         end
      end else if (v) begin
         ea_frame[ea_idx*2 +: 2] = data;
         ea_idx++;
         accepts_a++;
         if (ea_idx == 4 || last) begin
            qa.push_back({3'(ea_idx), ea_frame});
            ea_frame = '0;
            ea_idx   = 0;
            ea_fill  = 1'b0;
         end
      end
      @(posedge clk);
   endtask

   // One cycle on instance B with the same checking as tick_a.
   task automatic tick_b(input logic v, input logic [5:0] data, input logic last, input logic ordy);
      @(negedge clk);
      in_valid_b = v; in_data_b = data; in_last_b = last; out_ready_b = ordy;
      #1;
      checks++;
      if (in_ready_b !== eb_fill) begin
         failures++;
         $display("FAIL b_in_ready got=%b exp=%b t=%0t", in_ready_b, eb_fill, $time);
      end
      checks++;
      if (out_valid_b !== ~eb_fill) begin
         failures++;
         $display("FAIL b_out_valid got=%b exp=%b t=%0t", out_valid_b, ~eb_fill, $time);
      end
      if (!eb_fill) begin
         checks++;
         if (qb.size() == 0) begin
            failures++;
            $display("FAIL b_frame no expected frame queued t=%0t", $time);
         end else begin
            if ({out_nlanes_b, out_data_b} !== qb[0]) begin
               failures++;
               $display("FAIL b_frame got n=%0d data=%h exp n=%0d data=%h t=%0t",
                        out_nlanes_b, out_data_b, qb[0][26:24], qb[0][23:0], $time);
            end
            if (ordy) begin
               void'(qb.pop_front());
               eb_fill = 1'b1;
            end
         end
      end else if (v) begin
         eb_frame[eb_idx*6 +: 6] = data;
         eb_idx++;
         if (eb_idx == 4 || last) begin
            qb.push_back({3'(eb_idx), eb_frame});
            frames_b++;
            eb_frame = '0;
            eb_idx   = 0;
            eb_fill  = 1'b0;
         end
      end
      @(posedge clk);
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      in_valid_a = 1'b1; in_data_a = 2'($urandom); in_last_a = 1'b0; out_ready_a = 1'b0;
      in_valid_b = 1'b1; in_data_b = 6'($urandom); in_last_b = 1'b1; out_ready_b = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      in_valid_a = 1'b0; in_valid_b = 1'b0;
      #1;
      checks++;
      if ({in_ready_a, out_valid_a, out_nlanes_a, out_data_a} !== {1'b1, 1'b0, 3'd0, 8'd0}) begin
         failures++;
         $display("FAIL reset_a got rdy=%b vld=%b n=%0d data=%h exp rdy=1 vld=0 n=0 data=00",
                  in_ready_a, out_valid_a, out_nlanes_a, out_data_a);
      end
      checks++;
      if ({in_ready_b, out_valid_b, out_nlanes_b, out_data_b} !== {1'b1, 1'b0, 3'd0, 24'd0}) begin
         failures++;
         $display("FAIL reset_b got rdy=%b vld=%b n=%0d data=%h exp rdy=1 vld=0 n=0 data=000000",
                  in_ready_b, out_valid_b, out_nlanes_b, out_data_b);
      end
      ea_fill = 1'b1; ea_idx = 0; ea_frame = '0; qa.delete();
      eb_fill = 1'b1; eb_idx = 0; eb_frame = '0; qb.delete();
   endtask

   // Checks the presented frame against fixed expected values.
   task automatic check_frame_a(input string name, input logic [7:0] exp_data, input logic [2:0] exp_n);
      @(negedge clk);
      #1;
      checks++;
      if ({out_valid_a, in_ready_a, out_nlanes_a, out_data_a} !== {1'b1, 1'b0, exp_n, exp_data}) begin
         failures++;
         $display("FAIL %s got vld=%b rdy=%b n=%0d data=%b exp vld=1 rdy=0 n=%0d data=%b",
                  name, out_valid_a, in_ready_a, out_nlanes_a, out_data_a, exp_n, exp_data);
      end
   endtask

   task automatic test_full_frame();
      tick_a(1'b1, 2'b01, 1'b0, 1'b0);
      tick_a(1'b1, 2'b10, 1'b0, 1'b0);
      tick_a(1'b1, 2'b11, 1'b0, 1'b0);
      tick_a(1'b1, 2'b00, 1'b0, 1'b0);
      check_frame_a("full_frame", 8'b00_11_10_01, 3'd4);
   endtask

   task automatic test_hold();
      int acc0;
      acc0 = accepts_a;
      repeat (5) tick_a(1'b1, 2'b11, 1'b0, 1'b0);
      checks++;
      if (accepts_a != acc0) begin
         failures++;
         $display("FAIL hold_no_accept got=%0d exp=%0d", accepts_a - acc0, 0);
      end
      tick_a(1'b1, 2'b11, 1'b0, 1'b1);
      tick_a(1'b0, 2'b00, 1'b0, 1'b0);
   endtask

   task automatic test_short_frame();
      tick_a(1'b1, 2'b11, 1'b0, 1'b0);
      tick_a(1'b1, 2'b10, 1'b1, 1'b0);
      check_frame_a("short_frame", 8'b00_00_10_11, 3'd2);
      tick_a(1'b0, 2'b00, 1'b0, 1'b1);
      // in_last on the final lane is an ordinary full frame.
      tick_a(1'b1, 2'b01, 1'b0, 1'b0);
      tick_a(1'b1, 2'b01, 1'b0, 1'b0);
      tick_a(1'b1, 2'b10, 1'b0, 1'b0);
      tick_a(1'b1, 2'b11, 1'b1, 1'b0);
      check_frame_a("last_on_lane3", 8'b11_10_01_01, 3'd4);
      tick_a(1'b0, 2'b00, 1'b0, 1'b1);
      // in_last on the first bundle gives a single-lane frame.
      tick_a(1'b1, 2'b10, 1'b1, 1'b0);
      check_frame_a("one_lane_frame", 8'b00_00_00_10, 3'd1);
      tick_a(1'b0, 2'b00, 1'b0, 1'b1);
   endtask

   task automatic test_reset_mid_frame();
      tick_a(1'b1, 2'b11, 1'b0, 1'b0);
      tick_a(1'b1, 2'b11, 1'b0, 1'b0);
      tick_a(1'b1, 2'b11, 1'b0, 1'b0);
      test_reset();
      tick_a(1'b1, 2'b10, 1'b0, 1'b0);
      tick_a(1'b1, 2'b01, 1'b1, 1'b0);
      check_frame_a("post_reset_short", 8'b00_00_01_10, 3'd2);
      tick_a(1'b0, 2'b00, 1'b0, 1'b1);
      tick_a(1'b1, 2'b10, 1'b0, 1'b0);
      tick_a(1'b1, 2'b01, 1'b0, 1'b0);
      tick_a(1'b1, 2'b11, 1'b0, 1'b0);
      tick_a(1'b1, 2'b10, 1'b0, 1'b0);
      check_frame_a("post_reset_full", 8'b10_11_01_10, 3'd4);
      tick_a(1'b0, 2'b00, 1'b0, 1'b1);
   endtask

   task automatic test_valid_gaps();
      logic       vpat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      logic [1:0] dpat [7] = '{2'b01, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00, 2'b11};
      int acc0;
      acc0 = accepts_a;
      for (int i = 0; i < 7; i++) tick_a(vpat[i], dpat[i], 1'b0, 1'b0);
      checks++;
      if (accepts_a - acc0 != 4) begin
         failures++;
         $display("FAIL gaps_accepts got=%0d exp=%0d", accepts_a - acc0, 4);
      end
      check_frame_a("gaps_frame", 8'b11_01_10_01, 3'd4);
      tick_a(1'b0, 2'b00, 1'b0, 1'b1);
   endtask

   task automatic test_random_wide();
      int cyc;
      cyc = 0;
      while (frames_b < 1000 && cyc < 30000) begin
         tick_b($urandom_range(0, 3) != 0, 6'($urandom), $urandom_range(0, 4) == 0,
                $urandom_range(0, 2) != 0);
         cyc++;
      end
      checks++;
      if (frames_b < 1000) begin
         failures++;
         $display("FAIL random_frames got=%0d exp>=%0d within %0d cycles", frames_b, 1000, cyc);
      end
      // Drain the last presented frame so it is compared as well.
      repeat (3) tick_b(1'b0, 6'd0, 1'b0, 1'b1);
   endtask

   initial begin
      rst = 1'b0;
      in_valid_a = 1'b0; in_data_a = '0; in_last_a = 1'b0; out_ready_a = 1'b0;
      in_valid_b = 1'b0; in_data_b = '0; in_last_b = 1'b0; out_ready_b = 1'b0;
      accepts_a = 0;
      frames_b  = 0;
      test_reset();
      test_full_frame();
      test_hold();
      test_short_frame();
      test_reset_mid_frame();
      test_valid_gaps();
      test_random_wide();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
